// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an asynchronous SRAM.
// Each transaction runs through SETUP, ACCESS (strobe held ACCESS_CYCLES cycles) and DONE.
// All outputs are registered.
// Optional macro SRAM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie.
// Without it, ties alternate between the requesters (round-robin).
module sram_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_drive,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;     // remaining ACCESS cycles after the current one
  logic        gnt_reg;     // requester owning the transaction in flight
  logic        we_reg;      // access type latched at grant time
`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic        last_grant_reg;
`endif

  logic              pick1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Choose the winner among the current requests and mux its request fields
  always_comb begin
    pick1 = 1'b0;
    if (req0 && req1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      pick1 = 1'b0;
`else
      pick1 = ~last_grant_reg;
`endif
    end else begin
      pick1 = req1;
    end
    sel_we    = pick1 ? we1    : we0;
    sel_addr  = pick1 ? addr1  : addr0;
    sel_wdata = pick1 ? wdata1 : wdata0;
  end

  // Transaction FSM; every output is driven from this register block
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      gnt_reg   <= 1'b0;
      we_reg    <= 1'b0;
      mem_we_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_drive <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            // Request fields are frozen here; later input changes are ignored
            gnt_reg   <= pick1;
            we_reg    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_drive <= sel_we;
            busy      <= 1'b1;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant_reg <= pick1;
`endif
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          cnt_reg <= 4'(ACCESS_CYCLES - 1);
          if (we_reg) mem_we_n <= 1'b0;
          else        mem_oe_n <= 1'b0;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            mem_we_n <= 1'b1;
            mem_oe_n <= 1'b1;
            // Read data is captured on the edge that ends the strobe
            if (!we_reg) begin
              if (gnt_reg) rdata1 <= mem_rdata;
              else         rdata0 <= mem_rdata;
            end
            if (gnt_reg) ack1 <= 1'b1;
            else         ack0 <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          mem_drive <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter.
// Instance a uses ACCESS_CYCLES=2 and instance b uses ACCESS_CYCLES=1.
// Each instance is backed by a small SRAM model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance a (ACCESS_CYCLES = 2)
  logic        a_req0, a_we0, a_req1, a_we1, a_ack0, a_ack1;
  logic [10:0] a_addr0, a_addr1, a_mem_addr;
  logic [7:0]  a_wdata0, a_wdata1, a_rdata0, a_rdata1, a_mem_wdata, a_mem_rdata;
  logic        a_mem_drive, a_mem_we_n, a_mem_oe_n, a_busy;
  // instance b (ACCESS_CYCLES = 1)
  logic        b_req0, b_we0, b_req1, b_we1, b_ack0, b_ack1;
  logic [10:0] b_addr0, b_addr1, b_mem_addr;
  logic [7:0]  b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_mem_wdata, b_mem_rdata;
  logic        b_mem_drive, b_mem_we_n, b_mem_oe_n, b_busy;

  sram_arbiter #(.ADDR_W(11), .DATA_W(8), .ACCESS_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset),
    .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0), .ack0(a_ack0), .rdata0(a_rdata0),
    .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1), .ack1(a_ack1), .rdata1(a_rdata1),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_drive(a_mem_drive), .mem_rdata(a_mem_rdata),
    .mem_we_n(a_mem_we_n), .mem_oe_n(a_mem_oe_n), .busy(a_busy)
  );

  sram_arbiter #(.ADDR_W(11), .DATA_W(8), .ACCESS_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_drive(b_mem_drive), .mem_rdata(b_mem_rdata),
    .mem_we_n(b_mem_we_n), .mem_oe_n(b_mem_oe_n), .busy(b_busy)
  );

  // SRAM models: write while WE# low, read data presented while OE# low
  logic [7:0] mem_a [0:2047];
  logic [7:0] mem_b [0:2047];
  always @(posedge clk) if (a_mem_we_n === 1'b0) mem_a[a_mem_addr] <= a_mem_wdata;
  always @(posedge clk) if (b_mem_we_n === 1'b0) mem_b[b_mem_addr] <= b_mem_wdata;
  assign a_mem_rdata = (a_mem_oe_n === 1'b0) ? mem_a[a_mem_addr] : 8'h00;
  assign b_mem_rdata = (b_mem_oe_n === 1'b0) ? mem_b[b_mem_addr] : 8'h00;

  int total = 0;
  int bad   = 0;
  int lows;
  int ackcnt;
  int n;
  logic [31:0] order [0:3];
  logic [31:0] exp_order [0:3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; WE#/OE# must never overlap
  task automatic step();
    @(posedge clk);
    #1;
    check("no_overlap_a", 32'(a_mem_we_n | a_mem_oe_n), 1);
    check("no_overlap_b", 32'(b_mem_we_n | b_mem_oe_n), 1);
  endtask

  initial begin
    reset = 1'b1;
    a_req0 = 0; a_we0 = 0; a_addr0 = '0; a_wdata0 = '0;
    a_req1 = 0; a_we1 = 0; a_addr1 = '0; a_wdata1 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_b[2047] = 8'hC3;

    // ---- reset values
    step(); step();
    check("rst_we_n",  32'(a_mem_we_n), 1);
    check("rst_oe_n",  32'(a_mem_oe_n), 1);
    check("rst_drive", 32'(a_mem_drive), 0);
    check("rst_ack",   32'({a_ack1, a_ack0}), 0);
    check("rst_busy",  32'(a_busy), 0);
    check("rst_addr",  32'(a_mem_addr), 0);
    check("rst_wdata", 32'(a_mem_wdata), 0);
    check("rst_rdata", 32'({a_rdata1, a_rdata0}), 0);
    reset = 1'b0;
    step();

    // ---- write 0x5A to 0x123 from req0 (cycle 0 = this IDLE cycle)
    a_req0 = 1; a_we0 = 1; a_addr0 = 11'h123; a_wdata0 = 8'h5A; lows = 0;
    step(); // cycle 1 SETUP
    check("setup_busy",  32'(a_busy), 1);
    check("setup_addr",  32'(a_mem_addr), 'h123);
    check("setup_drive", 32'(a_mem_drive), 1);
    check("setup_we_n",  32'(a_mem_we_n), 1);
    check("setup_oe_n",  32'(a_mem_oe_n), 1);
    // change request fields after the grant: must have no effect
    a_addr0 = 11'h0AA; a_we0 = 0; a_wdata0 = 8'hFF;
    step(); // cycle 2
    if (a_mem_we_n == 1'b0) lows++;
    check("acc_addr_latched",  32'(a_mem_addr), 'h123);
    check("acc_wdata_latched", 32'(a_mem_wdata), 'h5A);
    check("acc_drive",         32'(a_mem_drive), 1);
    check("acc_oe_n_write",    32'(a_mem_oe_n), 1);
    step(); // cycle 3
    if (a_mem_we_n == 1'b0) lows++;
    check("wr_ack0_early", 32'(a_ack0), 0);
    step(); // cycle 4 DONE
    if (a_mem_we_n == 1'b0) lows++;
    check("wr_ack0_cycle4", 32'(a_ack0), 1);
    check("wr_ack1_quiet",  32'(a_ack1), 0);
    check("done_drive",     32'(a_mem_drive), 1);
    check("done_addr",      32'(a_mem_addr), 'h123);
    check("wr_we_low_cycles", 32'(lows), 2);
    a_req0 = 0;
    step(); // cycle 5 IDLE
    check("wr_ack0_pulse", 32'(a_ack0), 0);
    check("idle_busy",     32'(a_busy), 0);
    check("sram_written",  32'(mem_a[11'h123]), 'h5A);
    check("sram_0aa_untouched", 32'(mem_a[11'h0AA]), 0);

    // ---- read 0x123 from req1
    a_req1 = 1; a_we1 = 0; a_addr1 = 11'h123; lows = 0;
    step(); if (a_mem_oe_n == 1'b0) lows++;
    check("rd_setup_drive", 32'(a_mem_drive), 0);
    step(); if (a_mem_oe_n == 1'b0) lows++;
    step(); if (a_mem_oe_n == 1'b0) lows++;
    check("rd_ack1_early", 32'(a_ack1), 0);
    step(); if (a_mem_oe_n == 1'b0) lows++;
    check("rd_ack1_cycle4", 32'(a_ack1), 1);
    check("rd_rdata1",      32'(a_rdata1), 'h5A);
    check("rd_rdata0_kept", 32'(a_rdata0), 0);
    check("rd_oe_low_cycles", 32'(lows), 2);
    a_req1 = 0;
    step();

    // ---- reset during ACCESS of a write
    a_req0 = 1; a_we0 = 1; a_addr0 = 11'h050; a_wdata0 = 8'h11;
    step(); // SETUP
    step(); // ACCESS
    check("abort_we_low", 32'(a_mem_we_n), 0);
    reset = 1'b1; a_req0 = 0;
    step();
    check("abort_we_n",  32'(a_mem_we_n), 1);
    check("abort_drive", 32'(a_mem_drive), 0);
    check("abort_busy",  32'(a_busy), 0);
    check("abort_ack",   32'({a_ack1, a_ack0}), 0);
    reset = 1'b0;
    ackcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (a_ack0 || a_ack1) ackcnt++;
    end
    check("abort_no_ack", 32'(ackcnt), 0);

    // ---- both requesters held from reset: grant order
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`else
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`endif
    a_req0 = 1; a_we0 = 0; a_addr0 = 11'h010;
    a_req1 = 1; a_we1 = 0; a_addr1 = 11'h020;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      step();
      if (a_ack0 && a_ack1) check("dual_ack", 32'({a_ack1, a_ack0}), 1);
      if (a_ack0)      begin order[n] = 0; n++; end
      else if (a_ack1) begin order[n] = 1; n++; end
    end
    a_req0 = 0; a_req1 = 0;
    check("grant_count", 32'(n), 4);
    for (int i = 0; i < 4; i++) check($sformatf("grant_order_%0d", i), order[i], exp_order[i]);
    step(); step();

    // ---- ACCESS_CYCLES = 1, read max address
    b_req0 = 1; b_we0 = 0; b_addr0 = 11'h7FF;
    step(); // cycle 1
    check("b_setup_oe_n", 32'(b_mem_oe_n), 1);
    step(); // cycle 2
    check("b_access_oe_n", 32'(b_mem_oe_n), 0);
    check("b_ack0_early",  32'(b_ack0), 0);
    step(); // cycle 3
    check("b_ack0_cycle3", 32'(b_ack0), 1);
    check("b_rdata0",      32'(b_rdata0), 'hC3);
    check("b_done_oe_n",   32'(b_mem_oe_n), 1);
    b_req0 = 0;
    step();
    check("b_ack0_pulse", 32'(b_ack0), 0);
    check("b_idle_busy",  32'(b_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
